// File: rtl/wave_voice_sched.sv
// Time-multiplexed tone-voice scheduler: walks every voice through one shared
// wave_lut read port per sample tick and accumulates a volume-scaled mix.
module wave_voice_sched #(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 16,
   localparam int VA_W      = $clog2(NUM_VOICES)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              sample_tick_in,
   input  logic              cfg_we_in,
   input  logic [VA_W+1:0]   cfg_addr_in,
   input  logic [15:0]       cfg_data_in,
   input  logic              wmem_we_in,
   input  logic [4:0]        wmem_addr_in,
   input  logic [3:0]        wmem_data_in,
   output logic [4:0]        lut_addr_out,
   output logic [2:0]        wave_type_out,
   input  logic [15:0]       lut_data_in,
   output logic [4:0]        mem_write_addr_out,
   output logic [3:0]        mem_write_data_out,
   output logic              mem_write_en_out,
   output logic [8+VA_W-1:0] mix_out,
   output logic              mix_valid_out,
   output logic              busy_out,
   output logic              overrun_out
);

   typedef enum logic [1:0] {IDLE, SETUP, CAPT, DONE} state_t;

   state_t              state, state_next;
   logic [PHASE_W-1:0]  freq  [NUM_VOICES];
   logic [2:0]          wtype [NUM_VOICES];
   logic [3:0]          vol   [NUM_VOICES];
   logic [PHASE_W-1:0]  phase [NUM_VOICES];
   logic [VA_W-1:0]     v, v_inc;
   logic                last_voice;
   logic [VA_W-1:0]     cfg_voice;
   logic [1:0]          cfg_field;
   logic [3:0]          sample;
   logic [7:0]          prod;
   logic [8+VA_W-1:0]   acc;
   logic                unused_bits;

   assign cfg_voice  = cfg_addr_in[VA_W+1:2];
   assign cfg_field  = cfg_addr_in[1:0];
   assign v_inc      = v + 1'b1;
   assign last_voice = (v == VA_W'(NUM_VOICES - 1));
   assign sample     = wtype[v][2] ? lut_data_in[15:12] : {4{lut_data_in[0]}};
   assign prod       = {4'b0, sample} * {4'b0, vol[v]};
   assign unused_bits = ^{lut_data_in[11:1], cfg_data_in};

   assign mem_write_addr_out = wmem_addr_in;
   assign mem_write_data_out = wmem_data_in;
   assign mem_write_en_out   = wmem_we_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sample_tick_in) state_next = SETUP;
         SETUP:   state_next = CAPT;
         CAPT:    state_next = last_voice ? DONE : SETUP;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            freq[i]  <= '0;
            wtype[i] <= '0;
            vol[i]   <= '0;
         end
      end else if (cfg_we_in) begin
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (cfg_voice == VA_W'(i)) begin
               case (cfg_field)
                  2'd0:    freq[i]  <= cfg_data_in[PHASE_W-1:0];
                  2'd1:    wtype[i] <= cfg_data_in[2:0];
                  2'd2:    vol[i]   <= cfg_data_in[3:0];
                  default: ;
               endcase
            end
         end
      end
   end

   // A phase-clear write overrides the advance of the voice being captured.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (cfg_we_in && cfg_voice == VA_W'(i) && cfg_field == 2'd3)
               phase[i] <= '0;
            else if (state == CAPT && v == VA_W'(i))
               phase[i] <= phase[i] + freq[i];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         v             <= '0;
         acc           <= '0;
         lut_addr_out  <= '0;
         wave_type_out <= '0;
         mix_out       <= '0;
         mix_valid_out <= 1'b0;
         busy_out      <= 1'b0;
         overrun_out   <= 1'b0;
      end else begin
         mix_valid_out <= 1'b0;
         busy_out      <= (state_next != IDLE);
         if (sample_tick_in && state != IDLE) overrun_out <= 1'b1;
         case (state)
            IDLE: begin
               if (sample_tick_in) begin
                  acc           <= '0;
                  v             <= '0;
                  lut_addr_out  <= phase[0][PHASE_W-1 -: 5];
                  wave_type_out <= wtype[0];
               end
            end
            CAPT: begin
               acc <= acc + (8 + VA_W)'(prod);
               if (last_voice) begin
                  lut_addr_out  <= '0;
                  wave_type_out <= '0;
               end else begin
                  v             <= v_inc;
                  lut_addr_out  <= phase[v_inc][PHASE_W-1 -: 5];
                  wave_type_out <= wtype[v_inc];
               end
            end
            DONE: begin
               mix_out       <= acc;
               mix_valid_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_voice_sched.sv
// Directed bench for wave_voice_sched with a behavioural wave_lut
// (type<4: square from address MSB on bit 0; type>=4: 4-bit memory on [15:12]).
module tb_wave_voice_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        wmem_we = 1'b0;
   logic [4:0]  wmem_addr = '0;
   logic [3:0]  wmem_data = '0;
   logic [4:0]  lut_addr;
   logic [2:0]  wave_type;
   logic [15:0] lut_data;
   logic [4:0]  mw_addr;
   logic [3:0]  mw_data;
   logic        mw_en;
   logic [9:0]  mix;
   logic        mix_valid;
   logic        busy;
   logic        overrun;

   logic [3:0]  lmem [32] = '{default: '0};

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wave_voice_sched #(.NUM_VOICES(4), .PHASE_W(16)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .sample_tick_in(tick),
      .cfg_we_in(cfg_we), .cfg_addr_in(cfg_addr), .cfg_data_in(cfg_data),
      .wmem_we_in(wmem_we), .wmem_addr_in(wmem_addr), .wmem_data_in(wmem_data),
      .lut_addr_out(lut_addr), .wave_type_out(wave_type), .lut_data_in(lut_data),
      .mem_write_addr_out(mw_addr), .mem_write_data_out(mw_data),
      .mem_write_en_out(mw_en), .mix_out(mix), .mix_valid_out(mix_valid),
      .busy_out(busy), .overrun_out(overrun)
   );

   always @(posedge clk) if (mw_en) lmem[mw_addr] <= mw_data;

   always_comb begin
      lut_data = '0;
      if (wave_type[2]) lut_data[15:12] = lmem[lut_addr];
      else              lut_data[0]     = lut_addr[4];
   end

   typedef enum int {OP_CFG, OP_WMEM, OP_TICK} op_t;
   typedef struct {
      op_t op;
      int  addr;
      int  data;
      int  exp;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input op_t op, input int a, input int d, input int e);
      vec_t r;
      r.op = op; r.addr = a; r.data = d; r.exp = e;
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cfg_write(input int voice, input int field, input int data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(voice * 4 + field); cfg_data = 16'(data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic wmem_write(input int a, input int d);
      @(negedge clk);
      wmem_we = 1'b1; wmem_addr = 5'(a); wmem_data = 4'(d);
      #1;
      check("wmem_pass", {int'(mw_en), int'(mw_addr), int'(mw_data)}, {1, a, d});
      @(negedge clk);
      wmem_we = 1'b0;
   endtask

   // lat counts posedges after the one that samples the tick (E0 -> 0).
   task automatic do_tick(output int m, output int lat);
      m = -1; lat = -1;
      @(negedge clk);
      tick = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         tick = 1'b0;
         if (mix_valid) begin
            lat = i; m = int'(mix);
            break;
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mix"}, int'(mix), 0);
      check({tag, "_valid"}, int'(mix_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
      check({tag, "_lut_addr"}, int'(lut_addr), 0);
      check({tag, "_wave_type"}, int'(wave_type), 0);
   endtask

   initial begin
      int m, lat, pulses, first;

      // wave memory: mem[0]=9, voice0 type4 vol2 freq0 -> 18 each tick
      add(OP_WMEM, 0, 9, 0);
      add(OP_WMEM, 31, 15, 0);
      add(OP_CFG, 0*4+1, 4, 0);
      add(OP_CFG, 0*4+2, 2, 0);
      add(OP_CFG, 0*4+0, 0, 0);
      add(OP_TICK, 0, 0, 18);
      add(OP_TICK, 0, 0, 18);
      add(OP_TICK, 0, 0, 18);
      // full mix: four voices at vol 15 pushed to upper half, then wrap
      for (int vv = 0; vv < 4; vv++) begin
         add(OP_CFG, vv*4+1, 0, 0);
         add(OP_CFG, vv*4+2, 15, 0);
         add(OP_CFG, vv*4+0, 16'h8000, 0);
         add(OP_CFG, vv*4+3, 0, 0);
      end
      add(OP_TICK, 0, 0, 0);
      add(OP_TICK, 0, 0, 900);
      add(OP_TICK, 0, 0, 0);

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      foreach (vecs[k]) begin
         case (vecs[k].op)
            OP_CFG:  cfg_write(vecs[k].addr / 4, vecs[k].addr % 4, vecs[k].data);
            OP_WMEM: wmem_write(vecs[k].addr, vecs[k].data);
            OP_TICK: begin
               do_tick(m, lat);
               check($sformatf("vec%0d_mix", k), m, vecs[k].exp);
               check($sformatf("vec%0d_latency", k), lat, 9);
            end
            default: ;
         endcase
      end

      // square wave: 16 ticks low, 16 high, then wraps back low
      for (int vv = 1; vv < 4; vv++) cfg_write(vv, 2, 0);
      cfg_write(0, 1, 0);
      cfg_write(0, 2, 15);
      cfg_write(0, 0, 16'h0800);
      cfg_write(0, 3, 0);
      for (int t = 1; t <= 33; t++) begin
         do_tick(m, lat);
         check($sformatf("square_t%0d", t), m, (t >= 17 && t <= 32) ? 225 : 0);
      end

      // phase clear on the CAPT(0) exit edge E2 beats the 0x1000 advance
      cfg_write(0, 0, 16'h1000);
      cfg_write(0, 3, 0);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(0 * 4 + 3); cfg_data = 16'hffff;
      @(negedge clk);
      cfg_we = 1'b0;
      m = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mix_valid) begin
            m = int'(mix);
            break;
         end
      end
      check("clear_scan_mix", m, 0);
      for (int t = 1; t <= 9; t++) begin
         do_tick(m, lat);
         check($sformatf("clear_after_t%0d", t), m, (t == 9) ? 225 : 0);
      end

      // overrun: second tick lands on E3 and must be ignored
      check("overrun_before", int'(overrun), 0);
      pulses = 0; first = -1;
      @(negedge clk);
      tick = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         tick = (i == 2);
         if (i == 8) check("overrun_busy_e8", int'(busy), 1);
         if (i == 9) check("overrun_busy_e9", int'(busy), 0);
         if (mix_valid) begin
            pulses++;
            if (first < 0) begin
               first = i;
               check("overrun_mix", int'(mix), 225);
            end
         end
      end
      check("overrun_pulses", pulses, 1);
      check("overrun_valid_edge", first, 9);
      check("overrun_flag", int'(overrun), 1);

      // reset in the middle of a scan
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (2) @(negedge clk);
      check("midscan_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (mix_valid) pulses++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (mix_valid) pulses++;
      end
      check("midreset_no_pulse", pulses, 0);
      check("midreset_busy", int'(busy), 0);
      do_tick(m, lat);
      check("post_reset_mix", m, 0);
      check("post_reset_latency", lat, 9);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wave_voice_sched.md
# wave_voice_sched

Time-multiplexed voice scheduler that shares one `wave_lut` read port among `NUM_VOICES` tone voices. On each sample tick it walks every voice in turn: it drives that voice's LUT address and wave type, captures the LUT output, scales it by the voice volume and accumulates it into one mixed sample. It also owns the per-voice phase accumulators and configuration registers. It forwards host writes to the LUT's wave-memory write port.

## Interface
- `NUM_VOICES`, 4: voice count; power of two, 2..8.
- `PHASE_W`, 16: phase accumulator width; 5..16.
- `VA_W`, clog2(NUM_VOICES): derived voice index width.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `sample_tick_in` input 1: one-cycle pulse that starts a mix scan.
- `cfg_we_in` input 1: config register write strobe.
- `cfg_addr_in` input VA_W+2: {voice, field}; field 0 freq, 1 wave type, 2 volume, 3 phase clear.
- `cfg_data_in` input 16: write data; fields take the low bits.
- `wmem_we_in` input 1: host wave-memory write strobe.
- `wmem_addr_in` input 5: host wave-memory address.
- `wmem_data_in` input 4: host wave-memory data.
- `lut_addr_out` output 5: to the `wave_lut` address input.
- `wave_type_out` output 3: to the `wave_lut` wave-type input.
- `lut_data_in` input 16: from the `wave_lut` data output.
- `mem_write_addr_out` output 5, `mem_write_data_out` output 4, `mem_write_en_out` output 1: combinational pass-through of the `wmem_*` inputs.
- `mix_out` output 8+VA_W: last completed mix.
- `mix_valid_out` output 1: one-cycle pulse when `mix_out` updates.
- `busy_out` output 1: high while a scan is in progress.
- `overrun_out` output 1: sticky flag; a tick arrived while busy.

## Operation
- Per-voice registers:
  - `freq[PHASE_W]`, `type[3]`, `vol[4]`, `phase[PHASE_W]`.
  - All reset to 0. Volume 0 silences a voice, but its phase still advances.
- Config writes take effect on the clock edge where `cfg_we_in` is sampled.
  - Field 3 writes `phase` to 0; data is ignored.
- The FSM has four states: IDLE, SETUP, CAPT, DONE. A voice index `v` counts 0..N-1.
  - IDLE: on `sample_tick_in`, clear the accumulator, set v=0, go to SETUP.
  - SETUP: drive `lut_addr_out` = phase[v][PHASE_W-1 -: 5] and `wave_type_out` = type[v]. Go to CAPT.
  - CAPT: hold the same address and type. On the exiting edge:
    - sample = type[v][2] ? lut_data_in[15:12] : {4{lut_data_in[0]}}.
    - acc += sample × vol[v], 8-bit product, no saturation.
    - phase[v] += freq[v] modulo 2^PHASE_W.
    - If v == N-1 go to DONE, else v++ and go to SETUP.
  - DONE: `mix_out` <= acc, pulse `mix_valid_out`, go to IDLE.
- The accumulator width is 8+VA_W. The worst case is N×225, which never overflows.
- Each sample uses the pre-advance phase.
- In IDLE, `lut_addr_out` and `wave_type_out` are 0.
- Tick in SETUP, CAPT or DONE: the tick is ignored, the scan is unaffected, and `overrun_out` is set. `overrun_out` is cleared only by reset.
- Tick in the same cycle `mix_valid_out` is high (the FSM is in IDLE): the tick is accepted.
- Config write to voice v during its own CAPT edge:
  - `vol`/`type` writes: the accumulation uses the old value; the new value is stored.
  - `freq` write: the phase advance uses the old `freq`.
  - Phase-clear write: the clear wins over the advance; `phase` = 0.
- Wave-memory writes pass through at any time, with no interaction with the scan.
- Reset mid-scan returns the FSM to IDLE. Every register and output goes to 0 and no `mix_valid_out` pulse is issued.

## Timing
- Tick sampled at edge E0. SETUP(v) occupies the cycle after E(2v), and CAPT(v) the cycle after E(2v+1).
- DONE follows E(2N).
- `mix_out` and `mix_valid_out` are updated at E(2N+1). Latency from tick to valid is 2N+1 cycles: 9 for N=4.
- `busy_out` is high from E0 until E(2N+1). Ticks must be at least 2N+1 cycles apart.
- All outputs are registered except the `mem_write_*` pass-through.

## Test plan
- **Reset:** assert `rst_n_in` mid-scan -> all outputs 0 and the FSM idle; the next tick gives `mix_out`=0 at 9 cycles.
- **Square wave:** voice0 type 0, vol 15, freq 0x0800; voices 1-3 vol 0 -> `mix_out` is 0 for ticks 1-16 and 225 for ticks 17-32, with a period of 32 ticks.
- **Wave memory:** write mem[0]=9 via `wmem_*`; voice0 type 4, vol 2, freq 0 -> `mix_out`=18 on every tick.
- **Full mix:**
  - Setup: all four voices type 0, vol 15, each with `phase` forced into the upper half by freq 0x8000 and one tick.
  - Response: the next tick gives `mix_out`=900 (0x384), and phase wraps to 0.
- **Overrun:** a tick at E0 plus a tick 3 cycles later -> the second tick is ignored, `overrun_out`=1, and `mix_valid_out` pulses once at E9.
- **Simultaneous events:** a phase-clear write to voice0 on the same edge as its CAPT exit, with freq 0x1000 -> `phase[0]`=0 afterwards.
